digit_entry_register: RTL
=========================

Name: digit_entry_register

Overview:
- Parametrised successor to the 16-bit enable/latch register, used as the calculator's operand entry register.
- Holds DIGITS BCD nibbles and tracks how many digits are significant.
- Supports keypad-style digit shift-in, backspace, clear, parallel load, and one shadow (memory) bank with save, swap and restore.
- Sits between the keypad decoder and the ALU/display path. All outputs are registered.

Parameters:
- DIGITS, 4, number of BCD digits held (2..8); data width is 4*DIGITS.
- CW, derived as $clog2(DIGITS+1), width of the digit count; not overridable.

Ports:
- Clk  in  1  system clock, rising edge.
- R  in  1  asynchronous active-low reset.
- EN  in  1  command strobe; command executes on a Clk edge with EN=1.
- CMD  in  3  command code (encodings under Decomposition).
- DIN  in  4  digit for DIGIT command.
- LD  in  4*DIGITS  parallel BCD value for LOAD.
- Q  out  4*DIGITS  current value, digit 0 in Q[3:0].
- CNT  out  CW  number of significant digits, 0..DIGITS.
- FULL  out  1  CNT==DIGITS.
- EMPTY  out  1  CNT==0.
- MQ  out  4*DIGITS  shadow (memory) value.
- ERR  out  1  one-cycle pulse: previous command rejected.

Behaviour:
- Reset (R=0, asynchronous, any time including mid-command): Q=0, CNT=0, MQ=0, shadow count=0, ERR=0, FULL=0, EMPTY=1.
- Update timing:
  - All state updates occur at posedge Clk with EN=1; results are visible the cycle after the edge.
  - EN=0: all state is held and ERR is cleared to 0.
- ERR behaviour:
  - ERR is registered: 1 for exactly the cycle after a rejected command, otherwise 0.
  - A rejected command leaves Q, CNT, MQ and the shadow count unchanged.
- NOP (0): no change.
- DIGIT (1):
  - DIN>9: reject.
  - FULL: reject.
  - CNT==0 and DIN==0: leading zero; no change, no error.
  - Otherwise: Q <= {Q[4*DIGITS-5:0], DIN}, CNT <= CNT+1.
- BACKSPACE (2):
  - EMPTY: reject.
  - Otherwise: Q <= {4'h0, Q[4*DIGITS-1:4]}, CNT <= CNT-1.
- CLEAR (3): Q <= 0, CNT <= 0. The shadow is untouched.
- LOAD (4):
  - Any LD nibble >9: reject.
  - Otherwise: Q <= LD, CNT <= (index of the most significant nonzero nibble)+1, or 0 if LD==0.
- SAVE (5): MQ <= Q, shadow count <= CNT.
- SWAP (6): {Q,CNT} and {MQ, shadow count} are exchanged atomically in one edge.
- RESTORE (7): Q <= MQ, CNT <= shadow count. The shadow is unchanged.
- Flags and invariants:
  - FULL and EMPTY are decoded from the registered CNT, so they have no extra latency.
  - CNT never leaves 0..DIGITS. No wrap-around in either direction.
  - Invariant: every nibble above position CNT-1 is zero.

Decomposition:
- Shared package calc_pkg holds:
  - localparams CMD_NOP..CMD_RESTORE (3'd0..3'd7);
  - BCD_MAX=4'd9;
  - a function that computes CW from DIGITS.
- One natural sub-module: bcd_sig_count. It is combinational, parametrised by DIGITS, and maps a 4*DIGITS vector to {valid_bcd, significant-digit count}. It is used for LOAD.
- Everything else stays in the top module: the state registers, command decode, and ERR register.

Test Plan:
- R pulsed low mid-sequence, asynchronous to Clk -> Q=0, CNT=0, MQ=0, EMPTY=1, FULL=0, ERR=0 immediately, before the next edge.
- DIGITS=4: DIGIT 1,2,3,4 -> Q=0x1234, CNT=4, FULL=1. Then DIGIT 5 -> ERR=1 for one cycle, Q stays 0x1234. Then DIGIT 0xB on a non-full value -> ERR=1.
- From empty: DIGIT 0 -> Q=0, CNT=0, ERR=0. On Q=0x1234: BACKSPACE x4 -> 0x0123, 0x0012, 0x0001, 0x0000 with CNT 3..0. A fifth BACKSPACE -> ERR=1.
- LOAD LD=0x0050 -> Q=0x0050, CNT=2. Then LOAD 0x00A1 -> ERR=1, Q stays 0x0050. Then LOAD 0x0000 -> CNT=0, EMPTY=1.
- Q=0x0042 (CNT 2): SAVE; CLEAR; DIGIT 7 -> Q=0x0007, MQ=0x0042. SWAP -> Q=0x0042, CNT=2, MQ=0x0007. RESTORE -> Q=0x0007, CNT=1.
- EN=0 with CMD=CLEAR held for 5 cycles -> no state change. Then EN=1 for 1 cycle -> Q=0 on the following cycle.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator operand path: command codes,
// the BCD digit limit and the digit-count width helper.
package calc_pkg;

  localparam logic [2:0] CMD_NOP       = 3'd0;
  localparam logic [2:0] CMD_DIGIT     = 3'd1;
  localparam logic [2:0] CMD_BACKSPACE = 3'd2;
  localparam logic [2:0] CMD_CLEAR     = 3'd3;
  localparam logic [2:0] CMD_LOAD      = 3'd4;
  localparam logic [2:0] CMD_SAVE      = 3'd5;
  localparam logic [2:0] CMD_SWAP      = 3'd6;
  localparam logic [2:0] CMD_RESTORE   = 3'd7;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Width needed to hold a count in 0..digits.
  function automatic int cw_of(input int digits);
    return $clog2(digits + 1);
  endfunction

endpackage

// File: rtl/bcd_sig_count.sv
// Combinational check of a packed BCD vector: flags any nibble above 9 and
// reports how many digits are significant (MS nonzero nibble index + 1).
module bcd_sig_count
  import calc_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic [4*DIGITS-1:0]          vec,
  output logic                         valid,
  output logic [cw_of(DIGITS)-1:0]     cnt
);

  localparam int CW = cw_of(DIGITS);

  // Scan low to high so the last nonzero nibble seen sets the count.
  always_comb begin
    valid = 1'b1;
    cnt   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (vec[4*i +: 4] > BCD_MAX) valid = 1'b0;
      if (vec[4*i +: 4] != 4'h0)   cnt   = CW'(i + 1);
    end
  end

endmodule

// File: rtl/digit_entry_register.sv
// Calculator operand entry register: DIGITS BCD nibbles with a significant
// digit count, keypad shift-in, backspace, clear, parallel load and one
// shadow bank (save / swap / restore). Rejected commands pulse ERR.
module digit_entry_register
  import calc_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                     Clk,
  input  logic                     R,
  input  logic                     EN,
  input  logic [2:0]               CMD,
  input  logic [3:0]               DIN,
  input  logic [4*DIGITS-1:0]      LD,
  output logic [4*DIGITS-1:0]      Q,
  output logic [cw_of(DIGITS)-1:0] CNT,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic [4*DIGITS-1:0]      MQ,
  output logic                     ERR
);

  localparam int CW = cw_of(DIGITS);
  localparam int DW = 4 * DIGITS;

  logic [DW-1:0] q_r, q_nx, mq_r, mq_nx;
  logic [CW-1:0] cnt_r, cnt_nx, mcnt_r, mcnt_nx;
  logic          err_r, err_nx;
  logic          full, empty;
  logic          ld_valid;
  logic [CW-1:0] ld_cnt;

  assign full  = (cnt_r == CW'(DIGITS));
  assign empty = (cnt_r == '0);

  bcd_sig_count #(.DIGITS(DIGITS)) u_ld_cnt (
    .vec   (LD),
    .valid (ld_valid),
    .cnt   (ld_cnt)
  );

  // Command decode: default is hold with ERR cleared; rejects only raise ERR.
  always_comb begin
    q_nx    = q_r;
    cnt_nx  = cnt_r;
    mq_nx   = mq_r;
    mcnt_nx = mcnt_r;
    err_nx  = 1'b0;
    if (EN) begin
      case (CMD)
        CMD_DIGIT: begin
          if (DIN > BCD_MAX || full) begin
            err_nx = 1'b1;
          end else if (!(empty && DIN == 4'h0)) begin
            // A leading zero on an empty register is swallowed silently.
            q_nx   = {q_r[DW-5:0], DIN};
            cnt_nx = cnt_r + CW'(1);
          end
        end
        CMD_BACKSPACE: begin
          if (empty) begin
            err_nx = 1'b1;
          end else begin
            q_nx   = {4'h0, q_r[DW-1:4]};
            cnt_nx = cnt_r - CW'(1);
          end
        end
        CMD_CLEAR: begin
          q_nx   = '0;
          cnt_nx = '0;
        end
        CMD_LOAD: begin
          if (!ld_valid) begin
            err_nx = 1'b1;
          end else begin
            q_nx   = LD;
            cnt_nx = ld_cnt;
          end
        end
        CMD_SAVE: begin
          mq_nx   = q_r;
          mcnt_nx = cnt_r;
        end
        CMD_SWAP: begin
          q_nx    = mq_r;
          cnt_nx  = mcnt_r;
          mq_nx   = q_r;
          mcnt_nx = cnt_r;
        end
        CMD_RESTORE: begin
          q_nx   = mq_r;
          cnt_nx = mcnt_r;
        end
        default: ;
      endcase
    end
  end

  // State and error registers; reset clears both banks at once.
  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      q_r    <= '0;
      cnt_r  <= '0;
      mq_r   <= '0;
      mcnt_r <= '0;
      err_r  <= 1'b0;
    end else begin
      q_r    <= q_nx;
      cnt_r  <= cnt_nx;
      mq_r   <= mq_nx;
      mcnt_r <= mcnt_nx;
      err_r  <= err_nx;
    end
  end

  assign Q     = q_r;
  assign CNT   = cnt_r;
  assign MQ    = mq_r;
  assign ERR   = err_r;
  assign FULL  = full;
  assign EMPTY = empty;

endmodule
